// File: rtl/seg7_page_scan_ctrl.sv
// seg7_page_scan_ctrl
// Captures a 64-bit DES word and shows it as four pages of four hex digits.
// A debounced pushbutton advances the page. The four digits of the current
// page are scanned one at a time through a shared digit code and active-low
// anode enables. Digit code 5'h1F blanks the downstream segment decoder.

module seg7_page_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] data_in,
    input  logic        data_valid,
    input  logic        psh,
    output logic [4:0]  digit,
    output logic [3:0]  an,
    output logic [1:0]  page,
    output logic        has_data
);

    localparam int unsigned RW = (REFRESH_DIV  > 2) ? $clog2(REFRESH_DIV)  : 1;
    localparam int unsigned DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [RW-1:0] REFRESH_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DB_PRESS = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] DB_REL   = 2'd3;

    logic [63:0]   data_reg;
    logic          ps_meta;
    logic          ps_sync;
    logic [1:0]    db_state;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_inc;
    logic          step;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic [5:0]    nib_base;

    // Next debounce count and bit offset of the nibble currently scanned
    always_comb begin
        db_inc   = db_cnt + DW'(1);
        nib_base = {page, idx, 2'b00};
    end

    // Two-flop synchroniser for the raw pushbutton
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_meta <= 1'b0;
            ps_sync <= 1'b0;
        end else begin
            ps_meta <= psh;
            ps_sync <= ps_meta;
        end
    end

    // Debounce FSM; emits a single-cycle step when a press is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_state <= IDLE;
            db_cnt   <= '0;
            step     <= 1'b0;
        end else begin
            step <= 1'b0;
            case (db_state)
                IDLE: begin
                    if (ps_sync) begin
                        db_state <= DB_PRESS;
                        db_cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!ps_sync) begin
                        db_state <= IDLE;
                    end else begin
                        db_cnt <= db_inc;
                        if (db_inc == DEBOUNCE_LAST) begin
                            db_state <= HELD;
                            step     <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!ps_sync) begin
                        db_state <= DB_REL;
                        db_cnt   <= '0;
                    end
                end
                DB_REL: begin
                    if (ps_sync) begin
                        db_state <= HELD;
                    end else begin
                        db_cnt <= db_inc;
                        if (db_inc == DEBOUNCE_LAST) begin
                            db_state <= IDLE;
                        end
                    end
                end
                default: begin
                    db_state <= IDLE;
                    db_cnt   <= '0;
                end
            endcase
        end
    end

    // Word capture and page stepping; a capture always returns to page 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg <= '0;
            has_data <= 1'b0;
            page     <= '0;
        end else if (data_valid) begin
            data_reg <= data_in;
            has_data <= 1'b1;
            page     <= '0;
        end else if (step && has_data) begin
            page <= page + 2'd1;
        end
    end

    // Free-running refresh divider advancing the scanned digit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REFRESH_LAST) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    // Registered anode and digit outputs, blank until a word is captured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an    <= '1;
            digit <= '1;
        end else if (!has_data) begin
            an    <= '1;
            digit <= '1;
        end else begin
            an    <= ~(4'b0001 << idx);
            digit <= {1'b0, data_reg[nib_base +: 4]};
        end
    end

endmodule

// File: tb/tb_seg7_page_scan_ctrl.sv
// Self-checking bench for seg7_page_scan_ctrl with a behavioural model based
// on edge counts and button run lengths.

module tb_seg7_page_scan_ctrl;

    localparam int unsigned RD = 4;
    localparam int unsigned DC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        psh = 1'b0;
    logic [4:0]  digit;
    logic [3:0]  an;
    logic [1:0]  page;
    logic        has_data;

    int checks = 0;
    int errors = 0;

    seg7_page_scan_ctrl #(
        .REFRESH_DIV (RD),
        .DEBOUNCE_CYC(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_valid(data_valid),
        .psh       (psh),
        .digit     (digit),
        .an        (an),
        .page      (page),
        .has_data  (has_data)
    );

    always #5 clk = ~clk;

    // Reference model state: n counts edges since reset, so the scanned
    // digit is (n / RD) % 4; button acceptance is a run-length rule on the
    // synchronised level (two edges behind psh).
    typedef struct {
        logic [63:0] data;
        logic        has;
        logic [1:0]  page;
        int unsigned n;
        logic        s1;
        logic        s2;
        logic        acc;
        logic        last_ps;
        int unsigned run;
        logic        step_pend;
        logic [3:0]  e_an;
        logic [4:0]  e_digit;
    } model_t;

    model_t mst;

    function automatic model_t model_next(model_t m, logic rn, logic dv,
                                          logic [63:0] din, logic p);
        model_t r = m;
        logic [1:0] k;
        logic ps_now;
        logic accept;
        if (!rn) begin
            r.data = '0; r.has = 1'b0; r.page = '0; r.n = 0;
            r.s1 = 1'b0; r.s2 = 1'b0; r.acc = 1'b0; r.last_ps = 1'b0;
            r.run = 0; r.step_pend = 1'b0;
            r.e_an = 4'hF; r.e_digit = 5'h1F;
            return r;
        end
        k = 2'((m.n / RD) % 4);
        r.e_an = 4'hF;
        r.e_digit = 5'h1F;
        if (m.has) begin
            r.e_an[k] = 1'b0;
            r.e_digit = {1'b0, 4'(m.data >> (16 * int'(m.page) + 4 * int'(k)))};
        end
        ps_now = m.s2;
        r.s2 = m.s1;
        r.s1 = p;
        r.run = (ps_now == m.last_ps) ? m.run + 1 : 1;
        r.last_ps = ps_now;
        accept = (ps_now != m.acc) && (r.run == DC);
        if (accept) r.acc = ps_now;
        if (dv) r.page = '0;
        else if (m.step_pend && m.has) r.page = m.page + 2'd1;
        if (dv) begin
            r.data = din;
            r.has = 1'b1;
        end
        r.step_pend = accept && ps_now;
        r.n = m.n + 1;
        return r;
    endfunction

    always @(posedge clk) mst <= model_next(mst, rst_n, data_valid, data_in, psh);

    task automatic test_reset;
        rst_n = 1'b0; psh = 1'b0; data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({an, digit, page, has_data} !== {4'b1111, 5'h1F, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset cyc %0d: an=%b digit=%h page=%0d has_data=%b, expected an=1111 digit=1f page=0 has_data=0",
                         i, an, digit, page, has_data);
            end
            psh = (i >= 3 && i < 9);
        end
    endtask

    task automatic test_display;
        logic [3:0] prev;
        logic [3:0] ea;
        logic [3:0] seq [4];
        int unsigned t;
        seq = '{4'hF, 4'hE, 4'hD, 4'hC};
        @(negedge clk);
        data_in = 64'h0123_4567_89AB_CDEF;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if (has_data !== 1'b1) begin
            errors++;
            $display("FAIL display_has: has_data=%b, expected 1", has_data);
        end
        prev = an;
        t = 0;
        while (!((an == 4'b1110) && (prev != 4'b1110)) && (t < 40)) begin
            prev = an;
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 40) begin
            errors++;
            $display("FAIL display_sync: an=%b never entered 1110 within 40 cycles, expected 1110", an);
        end
        for (int c = 0; c < 20; c++) begin
            ea = 4'hF;
            ea[(c / 4) % 4] = 1'b0;
            checks++;
            if ({an, digit} !== {ea, 1'b0, seq[(c / 4) % 4]}) begin
                errors++;
                $display("FAIL display_seq cyc %0d: an=%b digit=%h, expected an=%b digit=%h",
                         c, an, digit, ea, {1'b0, seq[(c / 4) % 4]});
            end
            checks++;
            if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                errors++;
                $display("FAIL display_model cyc %0d: an=%b digit=%h page=%0d has_data=%b, expected an=%b digit=%h page=%0d has_data=%b",
                         c, an, digit, page, has_data, mst.e_an, mst.e_digit, mst.page, mst.has);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_paging;
        for (int p = 1; p <= 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                checks++;
                if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                    errors++;
                    $display("FAIL paging_model p%0d cyc %0d: an=%b digit=%h page=%0d has_data=%b, expected an=%b digit=%h page=%0d has_data=%b",
                             p, i, an, digit, page, has_data, mst.e_an, mst.e_digit, mst.page, mst.has);
                end
                psh = (i < 10);
            end
            checks++;
            if (page !== 2'(p % 4)) begin
                errors++;
                $display("FAIL paging_page after press %0d: page=%0d, expected %0d", p, page, p % 4);
            end
        end
    endtask

    task automatic test_debounce;
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                checks++;
                if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                    errors++;
                    $display("FAIL debounce_model seg%0d cyc %0d: an=%b digit=%h page=%0d has_data=%b, expected an=%b digit=%h page=%0d has_data=%b",
                             seg, i, an, digit, page, has_data, mst.e_an, mst.e_digit, mst.page, mst.has);
                end
                case (seg)
                    0:       psh = (i < 2);
                    1:       psh = (i < 8) || (i == 9) || (i == 11);
                    default: psh = (i < 8);
                endcase
            end
            checks++;
            if (page !== 2'(seg)) begin
                errors++;
                $display("FAIL debounce_page seg%0d: page=%0d, expected %0d", seg, page, seg);
            end
        end
    endtask

    task automatic test_collision;
        logic found;
        logic [4:0] ed;
        found = 1'b0;
        psh = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            checks++;
            if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                errors++;
                $display("FAIL collision_model cyc %0d: an=%b digit=%h page=%0d, expected an=%b digit=%h page=%0d",
                         i, an, digit, page, mst.e_an, mst.e_digit, mst.page);
            end
            if (mst.step_pend) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL collision_step: no accepted press within 20 cycles, expected one");
        end
        data_in = 64'hFFFF_0000_0000_1234;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        checks++;
        if ({page, has_data} !== {2'd0, 1'b1}) begin
            errors++;
            $display("FAIL collision_page: page=%0d has_data=%b, expected page=0 has_data=1", page, has_data);
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            psh = 1'b0;
            case (an)
                4'b1110: ed = 5'h04;
                4'b1101: ed = 5'h03;
                4'b1011: ed = 5'h02;
                4'b0111: ed = 5'h01;
                default: ed = 5'h1F;
            endcase
            checks++;
            if ((an == 4'b1111) || (digit !== ed)) begin
                errors++;
                $display("FAIL collision_digit cyc %0d: an=%b digit=%h, expected one-hot-low an with digit=%h",
                         i, an, digit, ed);
            end
            checks++;
            if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                errors++;
                $display("FAIL collision_scan cyc %0d: an=%b digit=%h page=%0d, expected an=%b digit=%h page=%0d",
                         i, an, digit, page, mst.e_an, mst.e_digit, mst.page);
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int seg = 0; seg < 6; seg++) begin
            if (seg == 2) begin
                checks++;
                if (page !== 2'd2) begin
                    errors++;
                    $display("FAIL midreset_pre: page=%0d, expected 2", page);
                end
                rst_n = 1'b0;
                @(negedge clk);
                checks++;
                if ({an, digit, page, has_data} !== {4'b1111, 5'h1F, 2'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL midreset_regs: an=%b digit=%h page=%0d has_data=%b, expected an=1111 digit=1f page=0 has_data=0",
                             an, digit, page, has_data);
                end
                rst_n = 1'b1;
            end
            if (seg == 3) begin
                data_in = {$urandom, $urandom};
                data_valid = 1'b1;
            end
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                data_valid = 1'b0;
                checks++;
                if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                    errors++;
                    $display("FAIL midreset_model seg%0d cyc %0d: an=%b digit=%h page=%0d has_data=%b, expected an=%b digit=%h page=%0d has_data=%b",
                             seg, i, an, digit, page, has_data, mst.e_an, mst.e_digit, mst.page, mst.has);
                end
                case (seg)
                    0, 1, 2, 3: psh = (seg == 0) ? (i < 8) : 1'b1;
                    4:          psh = 1'b0;
                    default:    psh = (i < 8);
                endcase
            end
            if (seg == 3) begin
                checks++;
                if (page !== 2'd0) begin
                    errors++;
                    $display("FAIL midreset_held: page=%0d, expected 0 while button stays held", page);
                end
            end
        end
        checks++;
        if (page !== 2'd1) begin
            errors++;
            $display("FAIL midreset_repress: page=%0d, expected 1", page);
        end
    endtask

    task automatic test_random;
        int unsigned remain;
        remain = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++;
            if ({an, digit, page, has_data} !== {mst.e_an, mst.e_digit, mst.page, mst.has}) begin
                errors++;
                $display("FAIL random cyc %0d: an=%b digit=%h page=%0d has_data=%b, expected an=%b digit=%h page=%0d has_data=%b",
                         i, an, digit, page, has_data, mst.e_an, mst.e_digit, mst.page, mst.has);
            end
            if (remain == 0) begin
                psh = 1'($urandom_range(0, 1));
                remain = $urandom_range(1, 8);
            end else begin
                remain--;
            end
            data_valid = ($urandom_range(0, 29) == 0);
            data_in = {$urandom, $urandom};
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        data_valid = 1'b0;
        psh = 1'b0;
    endtask

    initial begin
        test_reset;
        test_display;
        test_paging;
        test_debounce;
        test_collision;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
